bidir_bus_ctrl: RTL and testbench
=================================

Name: bidir_bus_ctrl

Overview:
Half-duplex controller for a shared bidirectional data bus built from IOBUF-style pad buffers. It generates the pad-side drive data and tri-state controls, samples the pad readback, and inserts turnaround cycles so the FPGA and the far-end device never drive the bus at the same time. It sits between a simple command interface (PicoBlaze port logic or a DMA engine) and a WIDTH-bit array of bidirectional pad buffers.

Parameters:
WIDTH, 8, bus width in bits.
DRIVE_CYCLES, 1, cycles the bus is actively driven per write (minimum 1).
TURN_CYCLES, 2, turnaround/settle cycles after releasing the bus or before sampling (minimum 1).

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command request.
cmd_ready  output  1  controller idle; a command is accepted when cmd_valid and cmd_ready are both high at a clk edge.
cmd_write  input  1  1 = write (drive bus), 0 = read (sample bus).
cmd_data  input  WIDTH  write data, captured on acceptance.
wr_done  output  1  one-cycle pulse: write finished, bus released and turnaround complete.
rd_valid  output  1  one-cycle pulse: rd_data holds a new sample.
rd_data  output  WIDTH  last sampled bus value, held until the next read.
contention  output  1  sticky flag: readback mismatched drive data.
contention_clr  input  1  clears contention.
pad_i  output  WIDTH  data to the pad buffer I inputs.
pad_t  output  WIDTH  pad buffer T inputs, 1 = high-Z; all bits are always equal.
pad_o  input  WIDTH  pad buffer O readback.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction): pad_t = all ones (bus released at once), pad_i = 0, rd_data = 0, wr_done = 0, rd_valid = 0, contention = 0, state = IDLE, cmd_ready = 1 after reset deasserts.
- States: IDLE, DRIVE, TURN, SETTLE. cmd_ready = (state == IDLE). Commands offered while not ready are ignored; there is no queue.
- pad_t is 0 only in DRIVE. It is a registered output, so it is glitch-free.
- Write accepted at edge k:
  - pad_i <= cmd_data.
  - DRIVE occupies cycles k+1 through k+DRIVE_CYCLES.
  - TURN occupies the next TURN_CYCLES cycles with pad_t = 1 and pad_i held.
  - IDLE returns in cycle k+DRIVE_CYCLES+TURN_CYCLES+1, with wr_done high for that single cycle.
- Contention check: at the edge ending the last DRIVE cycle, if pad_o != pad_i then contention <= 1 from the next cycle. The flag stays set until contention_clr is high at an edge. If set and clear coincide, set wins.
- Read accepted at edge k:
  - SETTLE occupies cycles k+1 through k+TURN_CYCLES with pad_t = 1.
  - At the edge ending the last SETTLE cycle, rd_data <= pad_o.
  - rd_valid is high in cycle k+TURN_CYCLES+1, which is also IDLE, so a new command may be accepted in that cycle.
- Back-to-back commands: the earliest acceptance is the first IDLE cycle. Write then read gives at least TURN+TURN released cycles before the sample.
- A single down-counter, ceil(log2(max(DRIVE_CYCLES,TURN_CYCLES)+1)) bits wide, is loaded on each state entry. The state exits when the counter reaches 1.
- wr_done and rd_valid are never high in the same cycle. Both are 0 outside their defined cycle.

Test Plan:
- Reset asserted mid-DRIVE (pad_t = 0x00): pad_t goes to 0xFF in the same cycle without waiting for clk. After release, cmd_ready = 1 and all outputs hold their reset values.
- Write 0xA5 with defaults, pad_o looped to pad_i when pad_t = 0: pad_t = 0 for exactly 1 cycle with pad_i = 0xA5, then 2 high-Z cycles. wr_done pulses in cycle k+4 and contention stays 0.
- Read with pad_o = 0x3C driven by a bench model: pad_t stays 0xFF, rd_valid pulses in cycle k+3 with rd_data = 0x3C, and rd_data holds 0x3C afterwards.
- Write 0x55 while the bench forces pad_o = 0x54: contention = 1 from cycle k+2 and stays set. Pulsing contention_clr clears it. A clear coinciding with a new mismatch leaves contention = 1.
- Back-to-back write 0x11, read (pad_o = 0x22), write 0x33, with cmd_valid held high: each command is accepted only in its IDLE cycle, rd_data = 0x22, and pad_t = 0 never overlaps any SETTLE cycle.
- DRIVE_CYCLES = 3, TURN_CYCLES = 1: pad_t = 0 for exactly 3 cycles, 1 turnaround cycle follows, and wr_done pulses in cycle k+5.

Source files
------------

// File: rtl/bidir_bus_ctrl_if.sv
// Command, status and pad-buffer signals of the half-duplex bus controller.
// The master side is the command issuer plus the pad array; the slave side is the controller.
interface bidir_bus_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [WIDTH-1:0] cmd_data;
    logic             wr_done;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             contention;
    logic             contention_clr;
    logic [WIDTH-1:0] pad_i;
    logic [WIDTH-1:0] pad_t;
    logic [WIDTH-1:0] pad_o;

    modport master (
        output cmd_valid, cmd_write, cmd_data, contention_clr, pad_o,
        input  cmd_ready, wr_done, rd_valid, rd_data, contention, pad_i, pad_t
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_data, contention_clr, pad_o,
        output cmd_ready, wr_done, rd_valid, rd_data, contention, pad_i, pad_t
    );
endinterface

// File: rtl/bidir_bus_ctrl.sv
// Half-duplex controller for an array of IOBUF-style pads: drives, releases and samples
// the shared bus with turnaround cycles so both ends never drive at once.
module bidir_bus_ctrl #(
    parameter int WIDTH        = 8,
    parameter int DRIVE_CYCLES = 1,
    parameter int TURN_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            reset,
    bidir_bus_ctrl_if.slave bus
);
    localparam int MAXC = (DRIVE_CYCLES > TURN_CYCLES) ? DRIVE_CYCLES : TURN_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] C_DRIVE = CW'(DRIVE_CYCLES);
    localparam logic [CW-1:0] C_TURN  = CW'(TURN_CYCLES);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_TURN   = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_pad_i;
    logic             r_pad_t;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_wr_done;
    logic             r_rd_valid;
    logic             r_contention;

    logic w_ready;
    logic w_last;
    logic w_mismatch;

    assign w_ready    = (r_state == S_IDLE);
    assign w_last     = (r_cnt == C_ONE);
    // Readback is compared only at the edge that ends the final drive cycle.
    assign w_mismatch = (r_state == S_DRIVE) && w_last && (bus.pad_o != r_pad_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pad_i      <= '0;
            r_pad_t      <= 1'b1;
            r_rd_data    <= '0;
            r_wr_done    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_contention <= 1'b0;
        end else begin
            r_wr_done  <= 1'b0;
            r_rd_valid <= 1'b0;

            if (w_mismatch)
                r_contention <= 1'b1;
            else if (bus.contention_clr)
                r_contention <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_write) begin
                            r_pad_i <= bus.cmd_data;
                            r_pad_t <= 1'b0;
                            r_state <= S_DRIVE;
                            r_cnt   <= C_DRIVE;
                        end else begin
                            r_state <= S_SETTLE;
                            r_cnt   <= C_TURN;
                        end
                    end
                end
                S_DRIVE: begin
                    if (w_last) begin
                        r_pad_t <= 1'b1;
                        r_state <= S_TURN;
                        r_cnt   <= C_TURN;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_TURN: begin
                    if (w_last) begin
                        r_state   <= S_IDLE;
                        r_wr_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_SETTLE: begin
                    if (w_last) begin
                        r_rd_data  <= bus.pad_o;
                        r_rd_valid <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = w_ready;
    assign bus.wr_done    = r_wr_done;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_data    = r_rd_data;
    assign bus.contention = r_contention;
    assign bus.pad_i      = r_pad_i;
    assign bus.pad_t      = {WIDTH{r_pad_t}};
endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Directed bench for bidir_bus_ctrl: default instance driven from a cycle vector table,
// plus a DRIVE=3/TURN=1 instance and hand sequences for back-to-back and async reset.
module tb_bidir_bus_ctrl;
    logic clk;
    logic reset;

    bidir_bus_ctrl_if #(.WIDTH(8)) if0 ();
    bidir_bus_ctrl_if #(.WIDTH(8)) if1 ();

    bidir_bus_ctrl #(.WIDTH(8), .DRIVE_CYCLES(1), .TURN_CYCLES(2)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    bidir_bus_ctrl #(.WIDTH(8), .DRIVE_CYCLES(3), .TURN_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    logic       loop0;
    logic [7:0] ext0;

    // Far-end model: loops drive data back while the FPGA drives, else presents ext0.
    assign if0.pad_o = (loop0 && if0.pad_t == 8'h00) ? if0.pad_i : ext0;
    assign if1.pad_o = (if1.pad_t == 8'h00) ? if1.pad_i : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       v, w, clr, lp;
        logic [7:0] d, ext;
        logic       rdy, wd, rv, cont;
        logic [7:0] pt, pi, rdd;
    } vec_t;

    function automatic vec_t mk(logic v, logic w, logic [7:0] d, logic clr, logic lp,
                                logic [7:0] ext, logic rdy, logic [7:0] pt, logic [7:0] pi,
                                logic wd, logic rv, logic [7:0] rdd, logic cont);
        vec_t t;
        t.v = v; t.w = w; t.d = d; t.clr = clr; t.lp = lp; t.ext = ext;
        t.rdy = rdy; t.pt = pt; t.pi = pi; t.wd = wd; t.rv = rv; t.rdd = rdd; t.cont = cont;
        return t;
    endfunction

    vec_t tv[19];

    initial begin
        int cmdi;
        logic acc;

        // inputs of one cycle | outputs expected in the following cycle
        tv[0]  = mk(1, 1, 8'hA5, 0, 1, 8'h00,  0, 8'h00, 8'hA5, 0, 0, 8'h00, 0);
        tv[1]  = mk(0, 0, 8'h00, 0, 1, 8'h00,  0, 8'hFF, 8'hA5, 0, 0, 8'h00, 0);
        tv[2]  = mk(0, 0, 8'h00, 0, 1, 8'h00,  0, 8'hFF, 8'hA5, 0, 0, 8'h00, 0);
        tv[3]  = mk(0, 0, 8'h00, 0, 1, 8'h00,  1, 8'hFF, 8'hA5, 1, 0, 8'h00, 0);
        tv[4]  = mk(0, 0, 8'h00, 0, 1, 8'h00,  1, 8'hFF, 8'hA5, 0, 0, 8'h00, 0);
        tv[5]  = mk(1, 0, 8'h00, 0, 0, 8'h3C,  0, 8'hFF, 8'hA5, 0, 0, 8'h00, 0);
        tv[6]  = mk(0, 0, 8'h00, 0, 0, 8'h3C,  0, 8'hFF, 8'hA5, 0, 0, 8'h00, 0);
        tv[7]  = mk(0, 0, 8'h00, 0, 0, 8'h3C,  1, 8'hFF, 8'hA5, 0, 1, 8'h3C, 0);
        tv[8]  = mk(0, 0, 8'h00, 0, 0, 8'h00,  1, 8'hFF, 8'hA5, 0, 0, 8'h3C, 0);
        tv[9]  = mk(1, 1, 8'h55, 0, 0, 8'h54,  0, 8'h00, 8'h55, 0, 0, 8'h3C, 0);
        tv[10] = mk(0, 0, 8'h00, 0, 0, 8'h54,  0, 8'hFF, 8'h55, 0, 0, 8'h3C, 1);
        tv[11] = mk(0, 0, 8'h00, 0, 0, 8'h54,  0, 8'hFF, 8'h55, 0, 0, 8'h3C, 1);
        tv[12] = mk(0, 0, 8'h00, 0, 0, 8'h54,  1, 8'hFF, 8'h55, 1, 0, 8'h3C, 1);
        tv[13] = mk(0, 0, 8'h00, 1, 0, 8'h54,  1, 8'hFF, 8'h55, 0, 0, 8'h3C, 0);
        tv[14] = mk(1, 1, 8'h55, 0, 0, 8'h54,  0, 8'h00, 8'h55, 0, 0, 8'h3C, 0);
        tv[15] = mk(0, 0, 8'h00, 1, 0, 8'h54,  0, 8'hFF, 8'h55, 0, 0, 8'h3C, 1);
        tv[16] = mk(0, 0, 8'h00, 0, 0, 8'h54,  0, 8'hFF, 8'h55, 0, 0, 8'h3C, 1);
        tv[17] = mk(0, 0, 8'h00, 0, 0, 8'h54,  1, 8'hFF, 8'h55, 1, 0, 8'h3C, 1);
        tv[18] = mk(0, 0, 8'h00, 1, 0, 8'h54,  1, 8'hFF, 8'h55, 0, 0, 8'h3C, 0);

        reset = 1'b1;
        loop0 = 1'b1;
        ext0  = 8'h00;
        if0.cmd_valid = 1'b0; if0.cmd_write = 1'b0; if0.cmd_data = 8'h00; if0.contention_clr = 1'b0;
        if1.cmd_valid = 1'b0; if1.cmd_write = 1'b0; if1.cmd_data = 8'h00; if1.contention_clr = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst.pad_t", if0.pad_t, 8'hFF);
        chk("rst.pad_i", if0.pad_i, 8'h00);
        chk("rst.rd_data", if0.rd_data, 8'h00);
        chk("rst.wr_done", if0.wr_done, 0);
        chk("rst.rd_valid", if0.rd_valid, 0);
        chk("rst.contention", if0.contention, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.cmd_ready", if0.cmd_ready, 1);

        for (int i = 0; i < 19; i++) begin
            if0.cmd_valid      = tv[i].v;
            if0.cmd_write      = tv[i].w;
            if0.cmd_data       = tv[i].d;
            if0.contention_clr = tv[i].clr;
            loop0              = tv[i].lp;
            ext0               = tv[i].ext;
            @(negedge clk);
            chk($sformatf("v%0d.ready", i), if0.cmd_ready, tv[i].rdy);
            chk($sformatf("v%0d.pad_t", i), if0.pad_t, tv[i].pt);
            chk($sformatf("v%0d.pad_i", i), if0.pad_i, tv[i].pi);
            chk($sformatf("v%0d.wr_done", i), if0.wr_done, tv[i].wd);
            chk($sformatf("v%0d.rd_valid", i), if0.rd_valid, tv[i].rv);
            chk($sformatf("v%0d.rd_data", i), if0.rd_data, tv[i].rdd);
            chk($sformatf("v%0d.contention", i), if0.contention, tv[i].cont);
        end

        // Back-to-back write 0x11, read 0x22, write 0x33 with cmd_valid held high.
        if0.contention_clr = 1'b0;
        loop0 = 1'b1;
        ext0  = 8'h22;
        cmdi  = 0;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("b2b%0d.ready", c), if0.cmd_ready, (c == 0 || c == 4 || c == 7 || c == 11));
            chk($sformatf("b2b%0d.pad_t", c), if0.pad_t, (c == 1 || c == 8) ? 8'h00 : 8'hFF);
            chk($sformatf("b2b%0d.wr_done", c), if0.wr_done, (c == 4 || c == 11));
            chk($sformatf("b2b%0d.rd_valid", c), if0.rd_valid, (c == 7));
            if (c == 1) chk("b2b.pad_i1", if0.pad_i, 8'h11);
            if (c == 8) chk("b2b.pad_i2", if0.pad_i, 8'h33);
            if (c >= 7) chk($sformatf("b2b%0d.rd_data", c), if0.rd_data, 8'h22);
            if0.cmd_valid = (cmdi < 3);
            if0.cmd_write = (cmdi != 1);
            if0.cmd_data  = (cmdi == 0) ? 8'h11 : ((cmdi == 2) ? 8'h33 : 8'h00);
            acc = if0.cmd_valid && if0.cmd_ready;
            @(negedge clk);
            if (acc) cmdi++;
        end
        chk("b2b.accepted", cmdi, 3);
        chk("b2b.contention", if0.contention, 0);
        if0.cmd_valid = 1'b0;

        // Long drive, short turnaround instance.
        if1.cmd_valid = 1'b1;
        if1.cmd_write = 1'b1;
        if1.cmd_data  = 8'h5A;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) if1.cmd_valid = 1'b0;
            chk($sformatf("d3_%0d.pad_t", c), if1.pad_t, (c <= 3) ? 8'h00 : 8'hFF);
            chk($sformatf("d3_%0d.pad_i", c), if1.pad_i, 8'h5A);
            chk($sformatf("d3_%0d.wr_done", c), if1.wr_done, (c == 5));
            chk($sformatf("d3_%0d.ready", c), if1.cmd_ready, (c >= 5));
            chk($sformatf("d3_%0d.contention", c), if1.contention, 0);
        end

        // Asynchronous reset in the middle of DRIVE.
        if0.cmd_valid = 1'b1;
        if0.cmd_write = 1'b1;
        if0.cmd_data  = 8'h77;
        @(posedge clk);
        #1;
        if0.cmd_valid = 1'b0;
        chk("mid.pad_t_drive", if0.pad_t, 8'h00);
        #1 reset = 1'b1;
        #1;
        chk("mid.pad_t", if0.pad_t, 8'hFF);
        chk("mid.pad_i", if0.pad_i, 8'h00);
        chk("mid.rd_data", if0.rd_data, 8'h00);
        chk("mid.wr_done", if0.wr_done, 0);
        chk("mid.rd_valid", if0.rd_valid, 0);
        chk("mid.contention", if0.contention, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post.ready", if0.cmd_ready, 1);
        chk("post.pad_t", if0.pad_t, 8'hFF);
        chk("post.wr_done", if0.wr_done, 0);
        chk("post.rd_data", if0.rd_data, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
